// File: rtl/code_select_tracker_pkg.sv
// Shared types and helpers for the code selection tracker.
package code_select_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic MODE_STICKY = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  function automatic logic in_range(input int unsigned code, input int unsigned num_codes);
    return (code >= 1) && (code <= num_codes);
  endfunction

endpackage

// File: rtl/code_select_tracker_sat_counter.sv
// Per-code hit counter that saturates at all ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/code_select_tracker.sv
// Tracks a stream of code numbers: per-code status bitmap, seen mask,
// saturating hit counters, range errors and a completion FSM.
module code_select_tracker
  import code_select_pkg::*;
#(
  parameter int unsigned NUM_CODES = 18,
  parameter int unsigned DATA_W    = $clog2(NUM_CODES + 1),
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_CODES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 data_val_i,
  input  logic                 mode_i,
  input  logic                 clear_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [CNT_W-1:0]     rd_cnt_o,
  output logic [NUM_CODES-1:0] status_o,
  output logic                 range_err_o,
  output logic                 all_seen_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  logic                 code_ok;
  logic                 accept;
  logic                 range_bad;
  logic [NUM_CODES-1:0] hit;
  logic [NUM_CODES-1:0] status_q, status_d;
  logic [NUM_CODES-1:0] seen_q, seen_d;
  logic                 all_seen_q;
  logic                 done_q, done_d;
  logic                 range_err_q;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]     cnt [NUM_CODES];
  state_t               state_q, state_d;

  // Clear takes priority: a code arriving with clear is neither counted nor flagged.
  always_comb begin
    code_ok   = in_range(32'(data_i), NUM_CODES);
    accept    = data_val_i & ~clear_i & code_ok;
    range_bad = data_val_i & ~clear_i & ~code_ok;
    hit       = '0;
    for (int unsigned i = 0; i < NUM_CODES; i++) begin
      hit[i] = accept && (data_i == DATA_W'(i + 1));
    end
  end

  always_comb begin
    status_d = status_q;
    seen_d   = seen_q;
    if (clear_i) begin
      status_d = '0;
      seen_d   = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CODES; i++) begin
        if (hit[i]) begin
          status_d[i] = (mode_i == MODE_TOGGLE) ? ~status_q[i] : 1'b1;
          seen_d[i]   = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CODES; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (hit[g]),
      .clr_i (clear_i),
      .cnt_o (cnt[g])
    );
  end

  always_comb begin
    rd_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_CODES; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_cnt_d = cnt[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completion is judged on the post-update seen mask, so a single code
  // can carry IDLE straight to COMPLETE when NUM_CODES is 1.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (accept) state_d = (&seen_d) ? COMPLETE : COLLECT;
        COLLECT:  if (&seen_d) state_d = COMPLETE;
        COMPLETE: state_d = COMPLETE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    done_d  = (state_d == COMPLETE) && (state_q != COMPLETE);
    state_o = state_q;
    done_o  = done_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q    <= '0;
      seen_q      <= '0;
      all_seen_q  <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      rd_cnt_q    <= '0;
    end else begin
      status_q    <= status_d;
      seen_q      <= seen_d;
      all_seen_q  <= &seen_d;
      done_q      <= done_d;
      range_err_q <= range_bad;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign status_o    = status_q;
  assign all_seen_o  = all_seen_q;
  assign range_err_o = range_err_q;
  assign rd_cnt_o    = rd_cnt_q;

endmodule

// File: doc/code_select_tracker.md
Name: code_select_tracker

Overview:
- Parametrised successor to the fixed 18-code selection block.
- Accepts a stream of code numbers with a valid qualifier and maintains a per-code status bitmap in sticky or toggle mode.
- Also keeps a saturating hit counter per code, flags out-of-range codes and signals completion when every code has been seen.
- Sits between the code source (up to one code per clock) and the control/status logic that reads status and counters.

Parameters:
NUM_CODES, 18, number of valid codes; legal code values 1..NUM_CODES
DATA_W, $clog2(NUM_CODES+1), width of code input
CNT_W, 8, width of each per-code saturating hit counter
IDX_W, $clog2(NUM_CODES), width of counter read index

Ports:
clk_i  in  1  single clock, all logic on posedge
rst_i  in  1  reset, asynchronous, active-high
data_i  in  DATA_W  code number
data_val_i  in  1  data_i valid this cycle
mode_i  in  1  0 = sticky set, 1 = toggle; sampled with each accepted code
clear_i  in  1  synchronous clear of status, counters and FSM
rd_idx_i  in  IDX_W  counter read index (code-1)
rd_cnt_o  out  CNT_W  registered hit count of code rd_idx_i+1
status_o  out  NUM_CODES  bit k = code k+1 state
range_err_o  out  1  one-cycle pulse on out-of-range code
all_seen_o  out  1  level: every code hit at least once since clear
done_o  out  1  one-cycle pulse when all_seen_o rises
state_o  out  2  FSM state encoding

Behaviour:
- Reset (async assert, release synchronous to clk_i):
  - status_o, all counters, rd_cnt_o, range_err_o, all_seen_o and done_o = 0.
  - state_o = IDLE.
- Accepted code: data_val_i=1, clear_i=0 and 1 <= data_i <= NUM_CODES.
  - Effects are visible on the next clock edge (latency 1).
- Status update for an accepted code k:
  - mode_i=0: status_o[k-1] <= 1.
  - mode_i=1: status_o[k-1] <= ~status_o[k-1].
- Counter update for an accepted code k: hit counter of code k increments, saturating at 2^CNT_W-1 with no wrap.
- Seen mask:
  - An internal seen mask is set per accepted code, independent of mode; toggle mode does not clear it.
  - all_seen_o = &seen, registered.
- Out-of-range code: data_val_i=1 with data_i=0 or data_i>NUM_CODES.
  - range_err_o = 1 on the next cycle.
  - No status or counter change.
- data_val_i=0: data_i is ignored; no state change.
- clear_i=1:
  - Next cycle: status, seen, counters, all_seen_o = 0 and FSM -> IDLE.
  - Clear wins over a simultaneous valid code, which is dropped with no counter update and no range_err_o.
- rd_cnt_o:
  - Registered read, one cycle after rd_idx_i.
  - Reflects counter contents as of the previous edge; a same-cycle write is not bypassed.
  - rd_idx_i >= NUM_CODES reads 0.
- FSM (state_o encoding IDLE=0, COLLECT=1, COMPLETE=2):
  - IDLE -> COLLECT on the first accepted code.
  - COLLECT -> COMPLETE in the cycle the seen mask becomes all ones; done_o pulses for exactly that cycle.
  - COMPLETE holds while codes are still accepted and counted.
  - Any state -> IDLE on clear_i.
  - Out-of-range codes cause no transition.
- NUM_CODES=1: the first accepted code moves IDLE -> COMPLETE directly, with done_o pulsing.
- Reset asserted mid-operation: all outputs return to 0 and state_o to IDLE immediately, without waiting for a clock edge.

Decomposition:
- Package code_select_pkg:
  - typedef enum logic [1:0] state_t {IDLE, COLLECT, COMPLETE}.
  - Constant MODE_STICKY=1'b0 and MODE_TOGGLE=1'b1.
  - Function in_range(code, num_codes).
- Sub-module sat_counter (parameter CNT_W; ports inc, clr, cnt): instantiated NUM_CODES times in a generate loop.
- Top-level holds the decode, status/seen registers, FSM and read mux.

Test Plan:
- Reset then codes 3, 3, 7 with mode_i=0 -> status_o bits 2 and 6 set; rd_idx_i=2 gives rd_cnt_o=2 one cycle later; state_o=COLLECT.
- mode_i=1, code 5 three times -> status_o[4] goes 1, 0, 1; all_seen_o stays 0; counter for code 5 = 3.
- Codes 0 and 19 with NUM_CODES=18 -> range_err_o pulses once per code; status_o and counters unchanged; state_o stays IDLE.
- Codes 1..18 in order -> done_o pulses exactly in the cycle after code 18 is accepted; all_seen_o=1; state_o=COMPLETE; a further code 4 keeps COMPLETE and counter for code 4 = 2.
- CNT_W=4, code 2 twenty times -> counter for code 2 saturates at 15.
- clear_i together with data_val_i=1 and code 9 -> next cycle all status and counters are 0, state_o=IDLE, code 9 count stays 0. Also assert rst_i asynchronously mid-stream -> outputs go to 0 before the next clock edge.
